pipe_stage_skid: RTL

//  Parametrised pipeline stage register. Generalises the IF/ID latch into a

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Valid/ready pipeline stage register with a 2-entry skid buffer.
//   It adds flush with bubble insertion and a saturating stall-cycle counter.
//   in_ready is registered, so no combinational ready path runs through the stage.
//
// Parameters
//   PC_W    width of PC field
//   IR_W    width of instruction field
//   NOP_IR  IR value driven while out_valid=0
//   CNT_W   width of stall counter
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   flush      in   1      discard held and incoming entries
//   in_valid   in   1      upstream entry valid
//   in_ready   out  1      stage can accept (registered)
//   in_pc      in   PC_W   upstream PC
//   in_ir      in   IR_W   upstream instruction
//   out_valid  out  1      out_pc/out_ir hold a real entry
//   out_ready  in   1      downstream accepts this cycle
//   out_pc     out  PC_W   head PC, 0 when empty
//   out_ir     out  IR_W   head IR, NOP_IR when empty
//   stall_cnt  out  CNT_W  saturating count of out_valid & ~out_ready cycles
module pipe_stage_skid #(
  parameter int unsigned     PC_W   = 32,
  parameter int unsigned     IR_W   = 32,
  parameter logic [IR_W-1:0] NOP_IR = '0,
  parameter int unsigned     CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [IR_W-1:0]  in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [IR_W-1:0]  out_ir,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [PC_W-1:0]   r_main_pc;
  logic [IR_W-1:0]   r_main_ir;
  logic [PC_W-1:0]   r_skid_pc;
  logic [IR_W-1:0]   r_skid_ir;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_acc;
  logic              w_pop;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_acc     = in_valid & r_in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_pc    = out_valid ? r_main_pc : '0;
  assign out_ir    = out_valid ? r_main_ir : NOP_IR;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any transfer: the offered entry is dropped and
    // both held entries are invalidated (a pop this cycle still completes).
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is derived from the next state so it is available as a register.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_pc <= '0;
      r_main_ir <= NOP_IR;
      r_skid_pc <= '0;
      r_skid_ir <= NOP_IR;
    end else begin
      if (w_load_main_in) begin
        r_main_pc <= in_pc;
        r_main_ir <= in_ir;
      end else if (w_load_main_skid) begin
        r_main_pc <= r_skid_pc;
        r_main_ir <= r_skid_ir;
      end
      if (w_load_skid) begin
        r_skid_pc <= in_pc;
        r_skid_ir <= in_ir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
